data_path_regs: RTL and testbench
=================================

DATA_PATH_REGS -- requirements
Module: data_path_regs

Interface
REQ-001 Parameter Y_W, default 4, width of the y register.
REQ-002 Parameter Y_MAX, default 9, largest legal y value.
REQ-003 Parameter S_W, default 3, width of the s register.
REQ-004 Parameter S_MOD, default 3, modulus of s in add mode.
REQ-005 Parameter S_PRESET, default 6, value loaded into s by s_zero.
REQ-006 Ports SHALL be:
  clk  in  1  single clock, all state on rising edge
  rst  in  1  asynchronous, active-low reset
  y_en  in  1  y register write enable
  y_store_x  in  1  load y from x (priority over y_select_next)
  y_select_next  in  2  y update: 0 hold, 1 increment, 2 decrement, 3 clear
  x  in  Y_W  external load value for y
  s_en  in  1  s register write enable
  s_zero  in  1  preset s to S_PRESET (priority over s_add)
  s_add  in  1  1 = add s_step modulo S_MOD, 0 = subtract s_step
  s_step  in  2  step magnitude, 0..3
  y  out  Y_W  y register
  s  out  S_W  s register
  y_inc  out  1  combinational: s == S_MOD-1 (next add of 1 carries)
  y_wrap  out  1  one-cycle pulse, y passed Y_MAX->0 or 0->Y_MAX
  err  out  1  sticky error flag

Function
REQ-007 Updates SHALL take effect on the rising clk edge after enables are sampled; one-cycle latency; outputs y, s, y_wrap, err registered.
REQ-008 s update (s_en=1): s_zero=1 -> s=S_PRESET; else s_add=1 -> s=(s+s_step) mod S_MOD; else s=s-s_step, saturating at 0.
REQ-009 Subtract with s_step > s SHALL leave s=0 and set err.
REQ-010 s_en=0 SHALL hold s regardless of s_zero, s_add, s_step.
REQ-011 y update (y_en=1): y_store_x=1 -> y=x; else per y_select_next; y_en=0 holds y.
REQ-012 y_store_x with x > Y_MAX SHALL load Y_MAX and set err.
REQ-013 Decrement from 0 and increment from Y_MAX: behaviour per REQ-019; no other value changes err.
REQ-014 y_inc SHALL be combinational from s only, valid whenever s_en is low or high.
REQ-015 s and y updates in the same cycle SHALL be independent; y_inc reflects s before the edge.
REQ-016 err SHALL remain 1 once set until reset; y_wrap SHALL be 1 only in the cycle after a wrapping update.

Reset
REQ-017 rst=0 SHALL immediately force y=0, s=0, y_wrap=0, err=0 without waiting for clk.
REQ-018 Reset asserted mid-sequence SHALL discard any in-flight update; first update after rst release occurs on the first clk edge with rst=1.

Configuration
REQ-019 Macro DATA_PATH_WRAP_EN: defined -> increment at Y_MAX gives 0 and decrement at 0 gives Y_MAX, both pulse y_wrap; undefined -> y saturates at Y_MAX/0, y_wrap stays 0, and the saturating attempt sets err.

Verification
REQ-020 s_en=1,s_zero=1 then s_en=1,s_add=0,s_step=2 x3 cycles -> s=6,4,2,0, err=0.
REQ-021 s=0, s_add=1,s_step=1,s_en=1 x4 cycles -> s=1,2,0,1; y_inc=1 only while s=2.
REQ-022 y_en=1,y_store_x=1,x=7 then y_select_next=1 x3 -> y=7,8,9, then 0 with y_wrap pulse (WRAP_EN) or 9 with err=1 (no WRAP_EN).
REQ-023 s=2, s_add=0, s_step=3, s_en=1 -> s=0, err=1 and stays 1 across later legal updates.
REQ-024 x=12, y_store_x=1, y_en=1 -> y=9, err=1; y_en=0 next cycle with y_select_next=3 -> y stays 9.
REQ-025 y=5,s=4, drive rst=0 between clk edges -> y=0,s=0,err=0 before next edge; updates resume on first edge after release.

Source files
------------

// File: rtl/data_path_regs.sv
// y/s data-path register pair with saturating or wrapping y counter and a sticky error flag.
// Optional feature: define DATA_PATH_WRAP_EN to make y wrap Y_MAX<->0 instead of saturating.
module data_path_regs #(
  parameter int Y_W      = 4,
  parameter int Y_MAX    = 9,
  parameter int S_W      = 3,
  parameter int S_MOD    = 3,
  parameter int S_PRESET = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           y_en,
  input  logic           y_store_x,
  input  logic [1:0]     y_select_next,
  input  logic [Y_W-1:0] x,
  input  logic           s_en,
  input  logic           s_zero,
  input  logic           s_add,
  input  logic [1:0]     s_step,
  output logic [Y_W-1:0] y,
  output logic [S_W-1:0] s,
  output logic           y_inc,
  output logic           y_wrap,
  output logic           err
);

  localparam logic [Y_W-1:0] Y_TOP   = Y_W'(Y_MAX);
  localparam logic [S_W-1:0] S_PRE   = S_W'(S_PRESET);
  localparam logic [S_W-1:0] S_LAST  = S_W'(S_MOD - 1);
  localparam logic [S_W+1:0] S_MOD_W = (S_W + 2)'(S_MOD);

  typedef struct packed {
    logic [S_W-1:0] val;
    logic           err;
  } s_upd_t;

  typedef struct packed {
    logic [Y_W-1:0] val;
    logic           wrap;
    logic           err;
  } y_upd_t;

  // Subtraction floors at zero; an underflowing request is reported as an error.
  function automatic s_upd_t s_next_f(
    input logic [S_W-1:0] cur,
    input logic           zero,
    input logic           add,
    input logic [1:0]     step
  );
    s_upd_t         r;
    logic [S_W+1:0] cur_w;
    logic [S_W+1:0] step_w;
    logic [S_W+1:0] sum;
    r.val  = cur;
    r.err  = 1'b0;
    cur_w  = {2'b00, cur};
    step_w = {{S_W{1'b0}}, step};
    sum    = cur_w + step_w;
    if (zero) begin
      r.val = S_PRE;
    end else if (add) begin
      r.val = S_W'(sum % S_MOD_W);
    end else if (step_w > cur_w) begin
      r.val = '0;
      r.err = 1'b1;
    end else begin
      r.val = S_W'(cur_w - step_w);
    end
    return r;
  endfunction

  // Out-of-range loads clamp to Y_MAX; end-of-range steps wrap or saturate by build option.
  function automatic y_upd_t y_next_f(
    input logic [Y_W-1:0] cur,
    input logic           store,
    input logic [1:0]     sel,
    input logic [Y_W-1:0] xin
  );
    y_upd_t r;
    r.val  = cur;
    r.wrap = 1'b0;
    r.err  = 1'b0;
    if (store) begin
      if (xin > Y_TOP) begin
        r.val = Y_TOP;
        r.err = 1'b1;
      end else begin
        r.val = xin;
      end
    end else begin
      case (sel)
        2'd1: begin
          if (cur >= Y_TOP) begin
`ifdef DATA_PATH_WRAP_EN
            r.val  = '0;
            r.wrap = 1'b1;
`else
            r.val  = Y_TOP;
            r.err  = 1'b1;
`endif
          end else begin
            r.val = cur + Y_W'(1);
          end
        end
        2'd2: begin
          if (cur == '0) begin
`ifdef DATA_PATH_WRAP_EN
            r.val  = Y_TOP;
            r.wrap = 1'b1;
`else
            r.val  = '0;
            r.err  = 1'b1;
`endif
          end else begin
            r.val = cur - Y_W'(1);
          end
        end
        2'd3:    r.val = '0;
        default: r.val = cur;
      endcase
    end
    return r;
  endfunction

  s_upd_t s_nxt_p0;
  y_upd_t y_nxt_p0;

  always_comb begin
    s_nxt_p0 = s_next_f(s, s_zero, s_add, s_step);
    y_nxt_p0 = y_next_f(y, y_store_x, y_select_next, x);
  end

  assign y_inc = (s == S_LAST);

  // Stage boundary: next-state values registered into the architectural outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y      <= '0;
      s      <= '0;
      y_wrap <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (s_en) s <= s_nxt_p0.val;
      if (y_en) y <= y_nxt_p0.val;
      y_wrap <= y_en & y_nxt_p0.wrap;
      err    <= err | (s_en & s_nxt_p0.err) | (y_en & y_nxt_p0.err);
    end
  end

endmodule

// File: tb/tb_data_path_regs.sv
// Self-checking bench for data_path_regs: directed scenarios then randomized traffic vs an integer model.
module tb_data_path_regs;

  localparam int Y_W      = 4;
  localparam int Y_MAX    = 9;
  localparam int S_W      = 3;
  localparam int S_MOD    = 3;
  localparam int S_PRESET = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           y_en = 1'b0;
  logic           y_store_x = 1'b0;
  logic [1:0]     y_select_next = 2'd0;
  logic [Y_W-1:0] x = '0;
  logic           s_en = 1'b0;
  logic           s_zero = 1'b0;
  logic           s_add = 1'b0;
  logic [1:0]     s_step = 2'd0;
  logic [Y_W-1:0] y;
  logic [S_W-1:0] s;
  logic           y_inc;
  logic           y_wrap;
  logic           err;

  int errors = 0;
  int checks = 0;

  int my = 0, ms = 0, mwrap = 0, merr = 0;

  data_path_regs #(
    .Y_W(Y_W), .Y_MAX(Y_MAX), .S_W(S_W), .S_MOD(S_MOD), .S_PRESET(S_PRESET)
  ) dut (
    .clk(clk), .rst(rst), .y_en(y_en), .y_store_x(y_store_x),
    .y_select_next(y_select_next), .x(x), .s_en(s_en), .s_zero(s_zero),
    .s_add(s_add), .s_step(s_step), .y(y), .s(s), .y_inc(y_inc),
    .y_wrap(y_wrap), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one clock edge, written from the register rules.
  task automatic model_edge();
    int xi, st;
    xi = int'(x);
    st = int'(s_step);
    mwrap = 0;
    if (s_en) begin
      if (s_zero) ms = S_PRESET;
      else if (s_add) ms = (ms + st) % S_MOD;
      else if (st > ms) begin ms = 0; merr = 1; end
      else ms = ms - st;
    end
    if (y_en) begin
      if (y_store_x) begin
        if (xi > Y_MAX) begin my = Y_MAX; merr = 1; end
        else my = xi;
      end else if (y_select_next == 2'd1) begin
        if (my == Y_MAX) begin
`ifdef DATA_PATH_WRAP_EN
          my = 0; mwrap = 1;
`else
          merr = 1;
`endif
        end else my = my + 1;
      end else if (y_select_next == 2'd2) begin
        if (my == 0) begin
`ifdef DATA_PATH_WRAP_EN
          my = Y_MAX; mwrap = 1;
`else
          merr = 1;
`endif
        end else my = my - 1;
      end else if (y_select_next == 2'd3) begin
        my = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":y"}, 32'(y), 32'(my));
    chk({tag, ":s"}, 32'(s), 32'(ms));
    chk({tag, ":y_wrap"}, 32'(y_wrap), 32'(mwrap));
    chk({tag, ":err"}, 32'(err), 32'(merr));
  endtask

  task automatic step_check(input string tag);
    chk({tag, ":y_inc"}, 32'(y_inc), 32'(ms == S_MOD - 1));
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Asserts reset between edges, holds it over one edge, releases it mid-cycle.
  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    my = 0; ms = 0; mwrap = 0; merr = 0;
    #1;
    check_all({tag, ":imm"});
    chk({tag, ":imm:y_inc"}, 32'(y_inc), 32'(0));
    @(posedge clk);
    #1;
    check_all({tag, ":hold"});
    #2 rst = 1'b1;
  endtask

  task automatic idle();
    y_en = 0; y_store_x = 0; y_select_next = 0; x = 0;
    s_en = 0; s_zero = 0; s_add = 0; s_step = 0;
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    check_all("reset");
    chk("reset:y_inc", 32'(y_inc), 32'(0));
    @(posedge clk);
    #1;
    check_all("reset_edge");
    #2 rst = 1'b1;

    // Preset then subtract by 2 down to zero.
    s_en = 1; s_zero = 1;
    step_check("preset");
    chk("preset:s6", 32'(s), 32'(6));
    s_zero = 0; s_add = 0; s_step = 2;
    step_check("sub1"); chk("sub1:s4", 32'(s), 32'(4));
    step_check("sub2"); chk("sub2:s2", 32'(s), 32'(2));
    step_check("sub3"); chk("sub3:s0", 32'(s), 32'(0));
    chk("sub3:err0", 32'(err), 32'(0));

    // Modulo-3 add by one; y_inc high while s is 2.
    s_add = 1; s_step = 1;
    step_check("add1"); chk("add1:s1", 32'(s), 32'(1));
    step_check("add2"); chk("add2:s2", 32'(s), 32'(2));
    chk("add2:y_inc", 32'(y_inc), 32'(1));
    step_check("add3"); chk("add3:s0", 32'(s), 32'(0));
    chk("add3:y_inc", 32'(y_inc), 32'(0));
    step_check("add4"); chk("add4:s1", 32'(s), 32'(1));
    step_check("add5");

    // s=2 subtract 3 underflows; err then stays set across a legal update.
    s_add = 0; s_step = 3;
    step_check("under"); chk("under:s0", 32'(s), 32'(0));
    chk("under:err", 32'(err), 32'(1));
    s_zero = 1;
    step_check("sticky"); chk("sticky:err", 32'(err), 32'(1));
    s_en = 0; s_zero = 0; s_add = 1; s_step = 3;
    step_check("s_hold"); chk("s_hold:s6", 32'(s), 32'(6));
    idle();
    async_reset("rst1");

    // Load 7, increment through Y_MAX.
    y_en = 1; y_store_x = 1; x = 7; y_select_next = 2'd3;
    step_check("load7"); chk("load7:y", 32'(y), 32'(7));
    y_store_x = 0; y_select_next = 2'd1;
    step_check("inc8"); chk("inc8:y", 32'(y), 32'(8));
    step_check("inc9"); chk("inc9:y", 32'(y), 32'(9));
    step_check("incmax");
`ifdef DATA_PATH_WRAP_EN
    chk("incmax:y", 32'(y), 32'(0));
    chk("incmax:wrap", 32'(y_wrap), 32'(1));
    chk("incmax:err", 32'(err), 32'(0));
    y_select_next = 2'd2;
    step_check("decmin"); chk("decmin:y", 32'(y), 32'(9));
    chk("decmin:wrap", 32'(y_wrap), 32'(1));
`else
    chk("incmax:y", 32'(y), 32'(9));
    chk("incmax:wrap", 32'(y_wrap), 32'(0));
    chk("incmax:err", 32'(err), 32'(1));
`endif
    y_en = 0;
    step_check("wrap_clr"); chk("wrap_clr:wrap", 32'(y_wrap), 32'(0));
    idle();
    async_reset("rst2");

    // Decrement from 0.
    y_en = 1; y_select_next = 2'd2;
    step_check("dec0");
    idle();
    async_reset("rst3");

    // Out-of-range load clamps; disabled clear holds.
    y_en = 1; y_store_x = 1; x = 12; y_select_next = 2'd2;
    step_check("load12"); chk("load12:y", 32'(y), 32'(9));
    chk("load12:err", 32'(err), 32'(1));
    y_en = 0; y_store_x = 0; y_select_next = 2'd3;
    step_check("yhold"); chk("yhold:y", 32'(y), 32'(9));
    idle();
    async_reset("rst4");

    // Mid-sequence reset discards the pending update; next edge after release updates.
    y_en = 1; y_store_x = 1; x = 5; s_en = 1; s_zero = 1;
    step_check("pre25a");
    y_en = 0; y_store_x = 0; s_zero = 0; s_add = 0; s_step = 2;
    step_check("pre25b");
    chk("pre25b:y5", 32'(y), 32'(5)); chk("pre25b:s4", 32'(s), 32'(4));
    y_en = 1; y_select_next = 2'd1; s_add = 1; s_step = 1;
    async_reset("rst5");
    step_check("resume");
    chk("resume:y1", 32'(y), 32'(1)); chk("resume:s1", 32'(s), 32'(1));

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      y_en          = ($urandom % 4) != 0;
      y_store_x     = ($urandom % 5) == 0;
      y_select_next = 2'($urandom % 4);
      x             = Y_W'($urandom % 16);
      s_en          = ($urandom % 4) != 0;
      s_zero        = ($urandom % 6) == 0;
      s_add         = 1'($urandom % 2);
      s_step        = 2'($urandom % 4);
      if (($urandom % 40) == 0) async_reset("rnd_rst");
      step_check("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
